pc_fetch_sequencer: RTL

- Owns the architectural program counter and sequences instruction fetch for the core.
- Drives the PC increment adder (pc + PC_STEP) and the next-PC select mux (sequential / branch / trap).
- Issues a level-sensitive request/acknowledge handshake to instruction memory.
- Provides fetch-accepted pulses to decode and a fetch counter for fault-campaign bookkeeping.

---
 rtl/pc_fetch_sequencer.sv | 65 ++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter owner and instruction-fetch sequencer (BOOT/FETCH/STALL).
// Optional `PC_FAULT_INJECT_EN` adds fault_strobe/fault_mask to XOR-corrupt the registered pc.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] PC_STEP     = 32'd4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
`ifdef PC_FAULT_INJECT_EN
    input  logic        fault_strobe,
    input  logic [31:0] fault_mask,
`endif
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;
    state_t state, state_n;
    logic redirect, accept;
    logic [31:0] pc_sel, inj;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= BOOT;
        else state <= state_n;
    always_comb
        state_n = (state == BOOT || redirect) ? FETCH :
                  state == FETCH ? ((accept && stall) ? STALL : FETCH) :
                  (stall ? STALL : FETCH);
    always_comb begin
        imem_req  = state == FETCH;
        imem_addr = pc;
    end
    // redirects are ignored in BOOT and discard any coincident ack
    always_comb begin
        redirect = state != BOOT && (trap || branch_taken);
        accept   = state == FETCH && imem_ack && !redirect;
        pc_sel   = !redirect ? (accept ? pc + PC_STEP : pc) :
                   trap ? TRAP_VECTOR : {branch_target[31:2], 2'b00};
    end
`ifdef PC_FAULT_INJECT_EN
    assign inj = (fault_strobe && state != BOOT) ? fault_mask : 32'h0;
`else
    assign inj = 32'h0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            fetch_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            pc          <= pc_sel ^ inj;
            fetch_valid <= accept;
            fetch_pc    <= accept ? pc : fetch_pc;
            fetch_count <= fetch_count + {31'h0, accept};
        end
endmodule
